instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Fetch front-end that sits directly upstream of the decode/control stage of the RV32I core.
- Generates sequential instruction-memory read requests over a valid/ready request channel.
- Collects the in-order responses into a DEPTH-entry FIFO and presents instruction+PC pairs to decode with a valid/ready handshake.
- Supports PC redirect: flushes the queue and discards responses still in flight.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2); also the cap on queued plus outstanding fetches.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  one-cycle pulse; flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  fetch address (word aligned).
- imem_rsp_valid  input  1  read data valid; responses return in request order and are always accepted.
- imem_rsp_data  input  32  instruction word.
- out_valid  output  1  queue head valid.
- out_ready  input  1  decode consumes head.
- out_instr  output  32  head instruction.
- out_pc  output  32  head PC.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = rsp_pc = RESET_PC.
  - FIFO count, outstanding and drop_cnt = 0.
  - out_valid = 0; out_instr and out_pc read 0.
  - imem_req_valid is 0 while rst is low and goes to 1 on the first cycle after release.
- Counters:
  - outstanding: width clog2(DEPTH)+1; +1 on request accept, -1 on response.
  - drop_cnt: same width.
- Request issue:
  - imem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid && ready), fetch_pc += 4. 32-bit wrap from 0xFFFF_FFFC to 0 is silent.
- Response handling:
  - If drop_cnt != 0: discard the response and drop_cnt -= 1.
  - Otherwise: push {imem_rsp_data, rsp_pc} and rsp_pc += 4.
  - The credit rule guarantees a push never hits a full FIFO. Overflow is a design error; a simulation-only assertion flags it.
- Output:
  - out_valid = (count != 0); head fields are registered.
  - Pop on out_valid && out_ready.
  - Response-to-out_valid latency is one cycle (no combinational bypass).
  - A simultaneous push and pop leaves count unchanged and preserves order.
- Redirect (highest priority):
  - Takes effect on the edge where redirect_valid = 1.
  - FIFO cleared (count = 0, pointers reset).
  - fetch_pc = rsp_pc = redirect_pc with bits [1:0] forced to 0.
  - drop_cnt = outstanding - imem_rsp_valid. A response arriving that same cycle is discarded and not pushed.
  - No request is issued in the redirect cycle. A same-cycle pop is ignored.
  - out_valid is 0 on the following cycle.
- Back-to-back redirects are legal: each one recomputes drop_cnt from the current outstanding count.
- A reset asserted mid-operation abandons all state immediately. The memory side must also be reset, so no stale responses survive.

Optional Feature:
- Macro: IPQ_MISALIGN_FAULT_EN.
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault, suppresses imem_req_valid and leaves the FIFO empty.
  - The fault persists until the next redirect with an aligned PC, which clears it and resumes fetch.
- Undefined:
  - Port absent.
  - Low two bits of redirect_pc are silently forced to 0 and fetching continues.

Test Plan:
- Reset release, imem_req_ready=1, memory returns data 1 cycle after request, out_ready=0 -> exactly DEPTH=4 requests (0x0, 0x4, 0x8, 0xC), then imem_req_valid=0. The FIFO holds 4 entries, with head out_pc=0x0.
- Continue with out_ready=1 -> one pop per cycle and fetches resume at 0x10. out_pc increments by 4 with no gaps or duplicates, and out_instr matches memory contents.
- With 2 requests outstanding and 1 queued entry, pulse redirect_valid with redirect_pc=0x100 -> next cycle out_valid=0 and the 2 stale responses are discarded. The first out_pc is 0x100 with the instruction at 0x100.
- Redirect in the same cycle as an imem_rsp_valid -> that response is not pushed, drop_cnt = outstanding-1, and no stale instruction reaches decode.
- Hold imem_req_ready=0 for 5 cycles after reset -> imem_req_addr stays at 0x0 and imem_req_valid stays 1. Then set ready=1 -> 0x0 is accepted and the address advances to 0x4.
- IPQ_MISALIGN_FAULT_EN defined, redirect_pc=0x102 -> fetch_fault=1 and no requests. A subsequent redirect to 0x200 -> fetch_fault=0 and the first request is at 0x200. With the macro undefined, 0x102 fetches from 0x100.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Purpose: RV32I fetch front-end; issues sequential imem reads and queues in-order responses for decode.
// Latency: response to out_valid is one cycle (registered FIFO, no bypass); redirect to first request is one cycle.
// Backpressure: credit-limited, queued + outstanding <= DEPTH; out_ready low stalls pops, imem_req_ready low holds the request.
//
// Ports:
//   clk, rst                       core clock (rising edge), asynchronous active-low reset
//   redirect_valid, redirect_pc    one-cycle flush pulse and new fetch address
//   imem_req_valid/ready/addr      instruction-memory read request channel
//   imem_rsp_valid, imem_rsp_data  in-order read responses (always accepted)
//   out_valid/ready, out_instr/pc  queue head presented to decode
//   fetch_fault                    only with IPQ_MISALIGN_FAULT_EN: sticky misaligned-redirect fault
//
// Optional feature macro: IPQ_MISALIGN_FAULT_EN. When undefined, redirect_pc[1:0] is silently
// cleared and fetching continues.

// Generic synchronous FIFO with registered storage; head_dat is read straight from the storage flops.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: none internally; the caller must never push into a full FIFO without a same-cycle pop.
module ipq_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      // Clear only rewinds the pointers; stale storage is hidden by count == 0.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_vld) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_vld) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (PW+1)'(push_vld) - (PW+1)'(pop_vld);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  // The upstream credit scheme makes overflow impossible; hitting this is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push_vld && !pop_vld && !clr && (count_q == (PW+1)'(DEPTH))));

endmodule

module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef IPQ_MISALIGN_FAULT_EN
  output logic [31:0] out_pc,
  output logic        fetch_fault
`else
  output logic [31:0] out_pc
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ipq_entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  // Holds requests off while reset is asserted; rises on the first edge after release.
  logic          run_q, run_d;

  logic [CW-1:0] fifo_count;
  ipq_entry_t    head_dat;
  ipq_entry_t    push_dat;
  logic          push_vld;
  logic          pop_vld;
  logic          req_acc;
  logic          credit_ok;
  logic          fetch_stop;
  logic [31:0]   redirect_pc_aligned;

`ifdef IPQ_MISALIGN_FAULT_EN
  logic fault_q, fault_d;
  assign fetch_stop  = fault_q;
  assign fetch_fault = fault_q;
`else
  assign fetch_stop  = 1'b0;
`endif

  // Every slot is either occupied in the FIFO or reserved by an in-flight fetch,
  // which includes stale fetches that will be dropped after a redirect.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);

  assign imem_req_valid = run_q && !fetch_stop && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_acc        = imem_req_valid && imem_req_ready;

  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  // A redirect cycle neither pushes the arriving response nor honours a pop.
  assign push_vld = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign pop_vld  = out_valid && out_ready && !redirect_valid;
  assign push_dat = '{instr: imem_rsp_data, pc: rsp_pc_q};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    run_d         = 1'b1;
    outstanding_d = outstanding_q + CW'(req_acc) - CW'(imem_rsp_valid);
`ifdef IPQ_MISALIGN_FAULT_EN
    fault_d       = fault_q;
`endif
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
`ifdef IPQ_MISALIGN_FAULT_EN
      fault_d    = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (req_acc) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      run_q         <= 1'b0;
`ifdef IPQ_MISALIGN_FAULT_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      run_q         <= run_d;
`ifdef IPQ_MISALIGN_FAULT_EN
      fault_q       <= fault_d;
`endif
    end
  end

  ipq_fifo #(
    .W     ($bits(ipq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect_valid),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_instr = head_dat.instr;
  assign out_pc    = head_dat.pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: random memory/decode/redirect traffic against a queue-based
// model (fetch stream tagged with a redirect generation), plus literal pins for the directed cases.
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IPQ_MISALIGN_FAULT_EN
  logic        fetch_fault;
`endif

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
`ifdef IPQ_MISALIGN_FAULT_EN
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
`else
    .out_pc         (out_pc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } env_req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int gen; } inf_t;

  env_req_t    env_q[$];     // memory side: requests the DUT really issued
  logic [31:0] acc_log[$];   // addresses accepted by memory, for directed checks
  ent_t        m_fifo[$];    // model: entries decode should see, in order
  inf_t        m_infl[$];    // model: fetches in flight, tagged with redirect generation
  logic [31:0] m_fetch_pc;
  int          m_gen;
  bit          m_run, m_fault, pred_vld;
  logic        dut_req_vld_s;
  logic [31:0] dut_req_addr_s;

  int cyc, n_checks, n_errors;
  int p_ready, p_out_ready, p_redirect, lat_extra;
  bit force_redir, force_on_rsp;
  logic [31:0] force_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic bit calc_pred();
    return m_run && !m_fault && !redirect_valid && ((m_fifo.size() + m_infl.size()) < DEPTH);
  endfunction

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFF0;
    else pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
    return pc;
  endfunction

  task automatic edge_update();
    env_req_t e;
    inf_t     r;
    cyc++;
    if (imem_rsp_valid && env_q.size() != 0) e = env_q.pop_front();
    if (dut_req_vld_s && imem_req_ready) begin
      env_q.push_back('{dut_req_addr_s, cyc + int'($urandom_range(0, lat_extra))});
      acc_log.push_back(dut_req_addr_s);
    end
    if (!redirect_valid && out_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
    if (imem_rsp_valid) begin
      if (m_infl.size() == 0) begin
        bound_fail("spurious_rsp");
      end else begin
        r = m_infl.pop_front();
        if (!redirect_valid && r.gen == m_gen) m_fifo.push_back('{r.addr, memf(r.addr)});
      end
    end
    if (pred_vld && imem_req_ready) begin
      m_infl.push_back('{m_fetch_pc, m_gen});
      m_fetch_pc += 32'd4;
    end
    if (redirect_valid) begin
      m_fifo.delete();
      m_gen++;
      m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IPQ_MISALIGN_FAULT_EN
      m_fault = (redirect_pc[1:0] != 2'b00);
`endif
    end
    m_run = 1'b1;
  endtask

  task automatic drive();
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    out_ready      = ($urandom_range(0, 99) < p_out_ready);
    if (env_q.size() != 0 && env_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(env_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (force_redir) begin
      if (!force_on_rsp || imem_rsp_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_pc;
        force_redir    = 1'b0;
      end
    end else if ($urandom_range(0, 99) < p_redirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = rnd_pc();
    end
  endtask

  task automatic compare();
    pred_vld       = calc_pred();
    dut_req_vld_s  = imem_req_valid;
    dut_req_addr_s = imem_req_addr;
    chk("req_valid", 32'(imem_req_valid), 32'(pred_vld));
    if (pred_vld) chk("req_addr", imem_req_addr, m_fetch_pc);
    chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      chk("out_pc", out_pc, m_fifo[0].pc);
      chk("out_instr", out_instr, m_fifo[0].instr);
    end
`ifdef IPQ_MISALIGN_FAULT_EN
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    edge_update();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    env_q.delete();
    m_fifo.delete();
    m_infl.delete();
    m_fetch_pc  = 32'h0;
    m_gen       = 0;
    m_run       = 1'b0;
    m_fault     = 1'b0;
    force_redir = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
`ifdef IPQ_MISALIGN_FAULT_EN
    chk("rst_fetch_fault", 32'(fetch_fault), 32'h0);
`endif
    @(negedge clk);
    rst            = 1'b1;
    pred_vld       = calc_pred();
    dut_req_vld_s  = imem_req_valid;
    dut_req_addr_s = imem_req_addr;
  endtask

  task automatic wait_out(input int bound, input string name);
    for (int i = 0; i < bound && !out_valid; i++) step();
    if (!out_valid) bound_fail(name);
  endtask

  task automatic wait_acc(input int bound, input string name);
    for (int i = 0; i < bound && acc_log.size() == 0; i++) step();
    if (acc_log.size() == 0) bound_fail(name);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0;
    force_redir = 1'b0; force_on_rsp = 1'b0; force_pc = '0;
    p_ready = 100; p_out_ready = 0; p_redirect = 0; lat_extra = 0;
    apply_reset();

    // Fill: exactly DEPTH fetches from 0x0, then the request stalls on credit.
    acc_log.delete();
    repeat (10) step();
    chk("fill_acc_cnt", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < acc_log.size()) chk("fill_acc_addr", acc_log[i], 32'(4 * i));
    chk("fill_head_valid", 32'(out_valid), 32'h1);
    chk("fill_head_pc", out_pc, 32'h0);
    chk("fill_head_instr", out_instr, memf(32'h0));
    chk("fill_req_stalled", 32'(imem_req_valid), 32'h0);

    // Drain: fetch resumes at 0x10.
    p_out_ready = 100;
    acc_log.delete();
    repeat (8) step();
    if (acc_log.size() != 0) chk("drain_resume_addr", acc_log[0], 32'h10);
    else bound_fail("drain_resume_addr");

    // Random traffic including redirects and an address wrap.
    p_ready = 70; p_out_ready = 60; p_redirect = 3; lat_extra = 2;
    repeat (400) step();
    force_pc = 32'hFFFF_FFF0; force_redir = 1'b1;
    repeat (100) step();

    // Directed redirect to 0x100 with fetches in flight.
    p_redirect = 0; p_ready = 100; p_out_ready = 30; lat_extra = 1;
    repeat (6) step();
    force_pc = 32'h100; force_redir = 1'b1;
    step();
    step();
    chk("redir_out_valid_low", 32'(out_valid), 32'h0);
    wait_out(40, "redir_wait");
    chk("redir_first_pc", out_pc, 32'h100);
    chk("redir_first_instr", out_instr, memf(32'h100));

    // Redirect coinciding with a response.
    p_out_ready = 50;
    force_pc = 32'h300; force_on_rsp = 1'b1; force_redir = 1'b1;
    for (int i = 0; i < 30 && force_redir; i++) step();
    if (force_redir) bound_fail("rsp_redir_hit");
    force_on_rsp = 1'b0; force_redir = 1'b0;
    step();
    chk("rsp_redir_out_valid_low", 32'(out_valid), 32'h0);
    wait_out(40, "rsp_redir_wait");
    chk("rsp_redir_first_pc", out_pc, 32'h300);

    // Reset mid-operation, then hold the request channel off.
    p_ready = 70;
    repeat (20) step();
    apply_reset();
    p_ready = 0;
    acc_log.delete();
    repeat (6) step();
    chk("stall_req_valid", 32'(imem_req_valid), 32'h1);
    chk("stall_req_addr", imem_req_addr, 32'h0);
    chk("stall_acc_cnt", 32'(acc_log.size()), 32'h0);
    p_ready = 100;
    step();
    step();
    chk("stall_acc_cnt_after", 32'(acc_log.size()), 32'h1);
    if (acc_log.size() != 0) chk("stall_first_acc", acc_log[0], 32'h0);
    chk("stall_next_addr", imem_req_addr, 32'h4);

    // Misaligned redirect.
    p_out_ready = 100;
    force_pc = 32'h102; force_redir = 1'b1;
    step();
    acc_log.delete();
`ifdef IPQ_MISALIGN_FAULT_EN
    repeat (10) step();
    chk("fault_set", 32'(fetch_fault), 32'h1);
    chk("fault_no_req", 32'(acc_log.size()), 32'h0);
    chk("fault_req_valid", 32'(imem_req_valid), 32'h0);
    force_pc = 32'h200; force_redir = 1'b1;
    step();
    acc_log.delete();
    wait_acc(20, "fault_resume_wait");
    if (acc_log.size() != 0) chk("fault_resume_addr", acc_log[0], 32'h200);
    chk("fault_cleared", 32'(fetch_fault), 32'h0);
`else
    wait_acc(20, "misalign_wait");
    if (acc_log.size() != 0) chk("misalign_addr", acc_log[0], 32'h100);
`endif

    // Closing random run.
    p_ready = 80; p_out_ready = 70; p_redirect = 2; lat_extra = 2;
    repeat (300) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
